// File: rtl/tetris_gravity_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tetris_gravity_scheduler
// Brief    : Programs an Avalon-MM interval timer for the game's gravity
//            frame rate, services its timeouts (clear status, emit a tick,
//            count frames), reprograms on a new period and stops it when
//            the game is disabled.
// Revision : 1.0 - initial release
// ============================================================================
module tetris_gravity_scheduler #(
  parameter logic [31:0] RESET_PERIOD = 32'h000CBDB7
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [31:0] cfg_period,
  input  logic        cfg_load,
  input  logic        timer_irq,
  output logic [2:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [15:0] m_writedata,
  output logic        tick,
  output logic [15:0] frame_count,
  output logic        busy
);

  // Interval-timer register map and the control/status words written to it
  localparam logic [2:0]  c_ADDR_STATUS  = 3'd0;
  localparam logic [2:0]  c_ADDR_CONTROL = 3'd1;
  localparam logic [2:0]  c_ADDR_PERIODL = 3'd2;
  localparam logic [2:0]  c_ADDR_PERIODH = 3'd3;
  localparam logic [15:0] c_CTL_START    = 16'h0007;  // ITO | CONT | START
  localparam logic [15:0] c_CTL_STOP     = 16'h0008;  // STOP
  localparam logic [15:0] c_STATUS_CLR   = 16'h0000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR_PL  = 3'd1,
    S_WR_PH  = 3'd2,
    S_WR_CTL = 3'd3,
    S_RUN    = 3'd4,
    S_CLR_ST = 3'd5,
    S_STOP   = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_period;
  logic        r_reload;
  logic [15:0] r_frame_count;
  logic [15:0] w_frame_next;
  logic [31:0] w_period_in;
  logic        w_enter_pl;

  logic [2:0]  r_m_address;
  logic        r_m_chipselect;
  logic        r_m_write_n;
  logic [15:0] r_m_writedata;
  logic        r_tick;
  logic        r_busy;

  // A zero period would make the timer fire continuously; clamp it to one
  assign w_period_in  = (cfg_period == 32'd0) ? 32'd1 : cfg_period;
  assign w_enter_pl   = (w_next == S_WR_PL) && (r_state != S_WR_PL);
  assign w_frame_next = (r_state == S_CLR_ST) ? (r_frame_count + 16'd1) : r_frame_count;

  // Next-state decode; RUN gives stop priority over irq service over reload
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (enable) w_next = S_WR_PL;
      S_WR_PL:  w_next = S_WR_PH;
      S_WR_PH:  w_next = S_WR_CTL;
      S_WR_CTL: w_next = S_RUN;
      S_RUN: begin
        if (!enable)        w_next = S_STOP;
        else if (timer_irq) w_next = S_CLR_ST;
        else if (r_reload)  w_next = S_WR_PL;
        else                w_next = S_RUN;
      end
      S_CLR_ST: w_next = S_RUN;
      S_STOP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // State register with bus/status outputs registered from the next state,
  // so each write is presented for exactly the cycle spent in its state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_m_address    <= 3'd0;
      r_m_chipselect <= 1'b0;
      r_m_write_n    <= 1'b1;
      r_m_writedata  <= 16'd0;
      r_tick         <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_m_address    <= 3'd0;
      r_m_chipselect <= 1'b0;
      r_m_write_n    <= 1'b1;
      r_m_writedata  <= 16'd0;
      r_tick         <= 1'b0;
      r_busy         <= 1'b0;
      case (w_next)
        S_WR_PL: begin
          r_m_address    <= c_ADDR_PERIODL;
          r_m_chipselect <= 1'b1;
          r_m_write_n    <= 1'b0;
          r_m_writedata  <= r_period[15:0];
          r_busy         <= 1'b1;
        end
        S_WR_PH: begin
          r_m_address    <= c_ADDR_PERIODH;
          r_m_chipselect <= 1'b1;
          r_m_write_n    <= 1'b0;
          r_m_writedata  <= r_period[31:16];
          r_busy         <= 1'b1;
        end
        S_WR_CTL: begin
          r_m_address    <= c_ADDR_CONTROL;
          r_m_chipselect <= 1'b1;
          r_m_write_n    <= 1'b0;
          r_m_writedata  <= c_CTL_START;
          r_busy         <= 1'b1;
        end
        S_CLR_ST: begin
          r_m_address    <= c_ADDR_STATUS;
          r_m_chipselect <= 1'b1;
          r_m_write_n    <= 1'b0;
          r_m_writedata  <= c_STATUS_CLR;
          r_tick         <= 1'b1;
        end
        S_STOP: begin
          r_m_address    <= c_ADDR_CONTROL;
          r_m_chipselect <= 1'b1;
          r_m_write_n    <= 1'b0;
          r_m_writedata  <= c_CTL_STOP;
          r_busy         <= 1'b1;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  // Period capture, reload flag (a new load beats the clear on WR_PL entry)
  // and the serviced-frame counter, which advances as CLR_ST is left
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_period      <= RESET_PERIOD;
      r_reload      <= 1'b0;
      r_frame_count <= 16'd0;
    end else begin
      if (cfg_load) begin
        r_period <= w_period_in;
        r_reload <= 1'b1;
      end else if (w_enter_pl) begin
        r_reload <= 1'b0;
      end
      r_frame_count <= w_frame_next;
    end
  end

  assign m_address    = r_m_address;
  assign m_chipselect = r_m_chipselect;
  assign m_write_n    = r_m_write_n;
  assign m_writedata  = r_m_writedata;
  assign tick         = r_tick;
  assign busy         = r_busy;
  assign frame_count  = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_tetris_gravity_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_tetris_gravity_scheduler
// Brief    : Scoreboard bench for tetris_gravity_scheduler. Expected bus
//            writes are queued as stimulus is applied and matched in order
//            against every write the DUT issues.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tetris_gravity_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [31:0] cfg_period;
  logic        cfg_load;
  logic        timer_irq;
  logic [2:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [15:0] m_writedata;
  logic        tick;
  logic [15:0] frame_count;
  logic        busy;

  typedef struct packed {
    logic [2:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t         sb_q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  logic [15:0] exp_fc;

  tetris_gravity_scheduler #(.RESET_PERIOD(32'h000CBDB7)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .cfg_period   (cfg_period),
    .cfg_load     (cfg_load),
    .timer_irq    (timer_irq),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata),
    .tick         (tick),
    .frame_count  (frame_count),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic push(input logic [2:0] a, input logic [15:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    sb_q.push_back(e);
  endtask

  task automatic push_prog(input logic [31:0] p);
    push(3'd2, p[15:0]);
    push(3'd3, p[31:16]);
    push(3'd1, 16'h0007);
  endtask

  // Bus monitor: every write must be the next queued one; idle cycles must
  // show a quiet bus; tick accompanies exactly the status-clear write
  always @(negedge clk) begin
    wr_t  e;
    logic exp_tick;
    if (reset_n === 1'b1) begin
      vectors++;
      exp_tick = (m_chipselect === 1'b1) && (m_write_n === 1'b0) && (m_address === 3'd0);
      if (m_chipselect === 1'b1 && m_write_n === 1'b0) begin
        if (sb_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_write: got addr=%0d data=%h at %0t, required no write",
                   m_address, m_writedata, $time);
        end else begin
          e = sb_q.pop_front();
          if (m_address !== e.a || m_writedata !== e.d) begin
            miscompares++;
            $display("FAIL bus_write: got addr=%0d data=%h at %0t, required addr=%0d data=%h",
                     m_address, m_writedata, $time, e.a, e.d);
          end
        end
      end else if (m_chipselect !== 1'b0 || m_write_n !== 1'b1 ||
                   m_address !== 3'd0 || m_writedata !== 16'd0) begin
        miscompares++;
        $display("FAIL idle_bus: got cs=%b wn=%b addr=%0d data=%h at %0t, required 0/1/0/0000",
                 m_chipselect, m_write_n, m_address, m_writedata, $time);
      end
      if (tick !== exp_tick) begin
        miscompares++;
        $display("FAIL tick_pulse: got %b at %0t, required %b", tick, $time, exp_tick);
      end
    end
  end

  task automatic wait_drain(input int maxc);
    int n = 0;
    while (sb_q.size() != 0 && n < maxc) begin
      @(negedge clk);
      #1;
      n++;
    end
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d writes outstanding, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    enable     = 1'b0;
    cfg_load   = 1'b0;
    cfg_period = 32'd0;
    timer_irq  = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({m_chipselect, m_write_n, m_address, m_writedata, tick, busy, frame_count} !==
        {1'b0, 1'b1, 3'd0, 16'd0, 1'b0, 1'b0, 16'd0}) begin
      miscompares++;
      $display("FAIL reset_state: got cs=%b wn=%b addr=%0d data=%h tick=%b busy=%b fc=%h, required 0/1/0/0000/0/0/0000",
               m_chipselect, m_write_n, m_address, m_writedata, tick, busy, frame_count);
    end
    enable = 1'b1;
    push_prog(32'h000CBDB7);
    reset_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_programming: got %b, required 1", busy);
    end
    wait_drain(6);
    @(negedge clk);
    exp_fc = 16'd0;
    vectors++;
    if (busy !== 1'b0 || frame_count !== exp_fc) begin
      miscompares++;
      $display("FAIL run_after_reset: got busy=%b fc=%h, required busy=0 fc=%h", busy, frame_count, exp_fc);
    end
  endtask

  task automatic test_irq();
    timer_irq = 1'b1;
    push(3'd0, 16'h0000);
    @(negedge clk);
    timer_irq = 1'b0;
    vectors++;
    if (tick !== 1'b1 || frame_count !== exp_fc) begin
      miscompares++;
      $display("FAIL irq_service: got tick=%b fc=%h, required tick=1 fc=%h", tick, frame_count, exp_fc);
    end
    @(negedge clk);
    exp_fc = exp_fc + 16'd1;
    vectors++;
    if (frame_count !== exp_fc || tick !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_count: got fc=%h tick=%b busy=%b, required fc=%h tick=0 busy=0",
               frame_count, tick, busy, exp_fc);
    end
  endtask

  task automatic test_reload();
    cfg_period = 32'h0001_2345;
    cfg_load   = 1'b1;
    push_prog(32'h0001_2345);
    @(negedge clk);
    cfg_load = 1'b0;
    wait_drain(8);
    @(negedge clk);
    // irq and reload arriving together: status clear is serviced first
    cfg_period = 32'h0ABC_1234;
    cfg_load   = 1'b1;
    timer_irq  = 1'b1;
    push(3'd0, 16'h0000);
    push_prog(32'h0ABC_1234);
    @(negedge clk);
    cfg_load  = 1'b0;
    timer_irq = 1'b0;
    vectors++;
    if (tick !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_before_reload: got tick=%b, required 1", tick);
    end
    wait_drain(10);
    @(negedge clk);
    exp_fc = exp_fc + 16'd1;
    vectors++;
    if (frame_count !== exp_fc || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reload_count: got fc=%h busy=%b, required fc=%h busy=0", frame_count, busy, exp_fc);
    end
  endtask

  task automatic test_zero_period();
    cfg_period = 32'd0;
    cfg_load   = 1'b1;
    push(3'd2, 16'h0001);
    push(3'd3, 16'h0000);
    push(3'd1, 16'h0007);
    @(negedge clk);
    cfg_load = 1'b0;
    wait_drain(8);
    @(negedge clk);
  endtask

  task automatic test_reload_collision();
    // Second load lands on the WR_PL entry edge; it must leave a reload pending
    cfg_period = 32'h0011_4444;
    cfg_load   = 1'b1;
    @(negedge clk);
    cfg_period = 32'h0022_4444;
    push_prog(32'h0022_4444);
    push_prog(32'h0022_4444);
    @(negedge clk);
    cfg_load = 1'b0;
    wait_drain(12);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL collision_settle: got busy=%b, required 0", busy);
    end
  endtask

  task automatic test_cfg_during_ph();
    cfg_period = 32'h0033_5555;
    cfg_load   = 1'b1;
    push_prog(32'h0033_5555);
    @(negedge clk);
    cfg_load = 1'b0;
    @(negedge clk);
    // WR_PL cycle: an irq here must be ignored
    timer_irq = 1'b1;
    @(negedge clk);
    // WR_PH cycle: new period arrives, current sequence completes first
    timer_irq  = 1'b0;
    cfg_period = 32'h0044_6666;
    cfg_load   = 1'b1;
    push_prog(32'h0044_6666);
    @(negedge clk);
    cfg_load = 1'b0;
    wait_drain(10);
    @(negedge clk);
    vectors++;
    if (frame_count !== exp_fc || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL cfg_during_ph: got fc=%h busy=%b, required fc=%h busy=0", frame_count, busy, exp_fc);
    end
  endtask

  task automatic test_stop();
    enable = 1'b0;
    push(3'd1, 16'h0008);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL stop_busy: got %b, required 1", busy);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || frame_count !== exp_fc) begin
      miscompares++;
      $display("FAIL stop_idle: got busy=%b fc=%h, required busy=0 fc=%h", busy, frame_count, exp_fc);
    end
    // irq in IDLE is ignored
    timer_irq = 1'b1;
    repeat (3) @(negedge clk);
    timer_irq = 1'b0;
    vectors++;
    if (frame_count !== exp_fc || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_in_idle: got fc=%h busy=%b, required fc=%h busy=0", frame_count, busy, exp_fc);
    end
    // enable drops during WR_PH: CTL, one RUN cycle, then STOP
    enable = 1'b1;
    push_prog(32'h0044_6666);
    push(3'd1, 16'h0008);
    @(negedge clk);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midseq_run: got busy=%b, required 0", busy);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midseq_stop: got busy=%b, required 1", busy);
    end
    @(negedge clk);
    wait_drain(2);
  endtask

  task automatic test_reset_midwrite();
    enable = 1'b1;
    push_prog(32'h0044_6666);
    @(negedge clk);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({m_chipselect, m_write_n, m_address, m_writedata, busy, frame_count} !==
        {1'b0, 1'b1, 3'd0, 16'd0, 1'b0, 16'd0}) begin
      miscompares++;
      $display("FAIL reset_midwrite: got cs=%b wn=%b addr=%0d data=%h busy=%b fc=%h, required 0/1/0/0000/0/0000",
               m_chipselect, m_write_n, m_address, m_writedata, busy, frame_count);
    end
    sb_q.delete();
    exp_fc = 16'd0;
    @(negedge clk);
    push_prog(32'h000CBDB7);
    reset_n = 1'b1;
    wait_drain(6);
    @(negedge clk);
  endtask

  task automatic test_wrap();
    force dut.r_frame_count = 16'hFFFD;
    @(negedge clk);
    release dut.r_frame_count;
    exp_fc = 16'hFFFD;
    vectors++;
    if (frame_count !== exp_fc) begin
      miscompares++;
      $display("FAIL wrap_preload: got %h, required %h", frame_count, exp_fc);
    end
    for (int i = 0; i < 3; i++) begin
      timer_irq = 1'b1;
      push(3'd0, 16'h0000);
      @(negedge clk);
      timer_irq = 1'b0;
      @(negedge clk);
      exp_fc = exp_fc + 16'd1;
      vectors++;
      if (frame_count !== exp_fc) begin
        miscompares++;
        $display("FAIL wrap_count: got %h, required %h", frame_count, exp_fc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_irq();
    test_reload();
    test_zero_period();
    test_reload_collision();
    test_cfg_during_ph();
    test_stop();
    test_reset_midwrite();
    test_wrap();
    wait_drain(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tetris_gravity_scheduler.md
TETRIS_GRAVITY_SCHEDULER -- requirements
Module: tetris_gravity_scheduler

Interface
REQ-001 SHALL have parameter RESET_PERIOD, default 32'h000CBDB7, period register value after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port enable  input  1  level; 1 = frame timer shall run.
REQ-005 SHALL have port cfg_period  input  32  new timer period (clk cycles minus one).
REQ-006 SHALL have port cfg_load  input  1  one-cycle strobe; capture cfg_period.
REQ-007 SHALL have port timer_irq  input  1  irq from the interval-timer slave.
REQ-008 SHALL have port m_address  output  3  Avalon-MM master word address to the timer.
REQ-009 SHALL have port m_chipselect  output  1  Avalon-MM master chipselect.
REQ-010 SHALL have port m_write_n  output  1  Avalon-MM master write, active low.
REQ-011 SHALL have port m_writedata  output  16  Avalon-MM master write data.
REQ-012 SHALL have port tick  output  1  one-cycle pulse per serviced timeout.
REQ-013 SHALL have port frame_count  output  16  serviced-timeout counter.
REQ-014 SHALL have port busy  output  1  high while a programming/stop sequence is in progress.

Function
REQ-015 SHALL implement states IDLE, WR_PL, WR_PH, WR_CTL, RUN, CLR_ST, STOP; each non-IDLE/RUN state lasts exactly one cycle, since the slave has no waitrequest.
REQ-016 SHALL, in each write state, drive m_chipselect=1 and m_write_n=0 for that cycle; all other cycles m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0.
REQ-017 SHALL drive WR_PL: address 2, data period_reg[15:0]; WR_PH: address 3, data period_reg[31:16]; WR_CTL: address 1, data 16'h0007 (irq enable, continuous, start); CLR_ST: address 0, data 16'h0000; STOP: address 1, data 16'h0008.
REQ-018 SHALL transition IDLE->WR_PL when enable=1; WR_PL->WR_PH->WR_CTL->RUN unconditionally.
REQ-019 SHALL, in RUN, evaluate in priority order: enable=0 -> STOP; timer_irq=1 -> CLR_ST; reload_pending=1 -> WR_PL; else stay in RUN.
REQ-020 SHALL transition CLR_ST->RUN and STOP->IDLE unconditionally.
REQ-021 SHALL assert tick for exactly the CLR_ST cycle and increment frame_count by 1 on leaving CLR_ST, wrapping 16'hFFFF->16'h0000.
REQ-022 SHALL, on cfg_load in any state, load period_reg <= cfg_period and set reload_pending; a cfg_period of 0 is stored as 1.
REQ-023 SHALL clear reload_pending on entry to WR_PL; cfg_load in the same cycle as WR_PL entry wins, leaving reload_pending set.
REQ-024 SHALL, when cfg_load arrives during WR_PL/WR_PH, let the writes already issued complete unchanged; the pending reload reprograms afterwards from RUN.
REQ-025 SHALL, when enable falls mid-sequence, finish the sequence to RUN, then go to STOP on the next cycle.
REQ-026 SHALL ignore timer_irq outside RUN.
REQ-027 SHALL drive busy=1 in WR_PL, WR_PH, WR_CTL, STOP and busy=0 otherwise; frame_count is not cleared by enable.

Reset
REQ-028 SHALL, on reset_n=0, asynchronously set state IDLE, period_reg=RESET_PERIOD, reload_pending=0, frame_count=0, tick=0, busy=0, m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0.
REQ-029 SHALL, when reset is asserted mid-write, drop the write in the same cycle; on release, restart from IDLE.

Verification
REQ-030 Reset release with enable=1 -> writes (2,16'hBDB7), (3,16'h000C), (1,16'h0007) on three consecutive cycles, then RUN with busy=0.
REQ-031 In RUN, pulse timer_irq high -> one cycle write (0,16'h0000), tick=1 in that cycle, frame_count 0->1.
REQ-032 cfg_load with cfg_period=32'h0001_2345 in RUN -> writes (2,16'h2345), (3,16'h0001), (1,16'h0007); with irq and reload both pending, CLR_ST goes first.
REQ-033 Deassert enable in RUN -> single write (1,16'h0008), then IDLE; deassert during WR_PH -> WR_CTL, then RUN, then STOP.
REQ-034 Preload frame_count=16'hFFFF via 65535 irqs, then one more irq -> frame_count=0.
REQ-035 cfg_load with cfg_period=0 -> period writes (2,16'h0001), (3,16'h0000).
